// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Two-requester arbiter that shares one single-port RAM between the LED
//   pattern counter (port 0) and a UART/debug loader (port 1). The RAM
//   registers its read address, so read data comes back one cycle after the
//   grant. Everything runs in the PLL output clock domain.
//
// Ports
//   clk_i, rst_ni          clock, synchronous active-low reset
//   reqN_i/weN_i           per-port request (held until granted), 1 = write
//   addrN_i/wdataN_i       per-port address and write data
//   gntN_o                 beat accepted this cycle (combinational)
//   rvalidN_o/rdataN_o     read response, one cycle after a granted read
//   mem_we_o/mem_addr_o/
//   mem_wdata_o            RAM command, muxed from the granted port
//   mem_rdata_i            RAM read data for the previous cycle's address
//
// Build option
//   ARB_FIXED_PRI_EN       when defined, port 0 has fixed priority (uncapped
//                          bursts, port 1 yields immediately and may starve).
//                          Default: round-robin with a MAX_BURST beat cap.
module ram_port_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req0_i,
    input  logic                  we0_i,
    input  logic [ADDR_WIDTH-1:0] addr0_i,
    input  logic [DATA_WIDTH-1:0] wdata0_i,
    input  logic                  req1_i,
    input  logic                  we1_i,
    input  logic [ADDR_WIDTH-1:0] addr1_i,
    input  logic [DATA_WIDTH-1:0] wdata1_i,
    output logic                  gnt0_o,
    output logic                  gnt1_o,
    output logic                  rvalid0_o,
    output logic                  rvalid1_o,
    output logic [DATA_WIDTH-1:0] rdata0_o,
    output logic [DATA_WIDTH-1:0] rdata1_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] beat_cnt;
    logic             last;
    logic             gnt0;
    logic             gnt1;
    logic             cnt_sat;

    assign cnt_sat = (beat_cnt == CNT_W'(MAX_BURST));

    // Grant decision; nothing is granted while reset is asserted.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_ni) begin
`ifdef ARB_FIXED_PRI_EN
            gnt0 = req0_i;
            gnt1 = req1_i & ~req0_i;
`else
            case (state)
                IDLE: begin
                    if (req0_i && req1_i) begin
                        // Tie goes to the port that was not served last.
                        if (last) gnt0 = 1'b1;
                        else      gnt1 = 1'b1;
                    end else begin
                        gnt0 = req0_i;
                        gnt1 = req1_i;
                    end
                end
                OWN0: begin
                    if (req0_i) begin
                        if (cnt_sat && req1_i) gnt1 = 1'b1;
                        else                   gnt0 = 1'b1;
                    end else begin
                        gnt1 = req1_i;
                    end
                end
                OWN1: begin
                    if (req1_i) begin
                        if (cnt_sat && req0_i) gnt0 = 1'b1;
                        else                   gnt1 = 1'b1;
                    end else begin
                        gnt0 = req0_i;
                    end
                end
                default: begin
                    gnt0 = 1'b0;
                    gnt1 = 1'b0;
                end
            endcase
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            last      <= 1'b1;
            rvalid0_o <= 1'b0;
            rvalid1_o <= 1'b0;
        end else begin
            rvalid0_o <= gnt0 & ~we0_i;
            rvalid1_o <= gnt1 & ~we1_i;
            if (gnt0) begin
                state <= OWN0;
                last  <= 1'b0;
                if (state != OWN0) beat_cnt <= CNT_W'(1);
                else if (!cnt_sat) beat_cnt <= beat_cnt + CNT_W'(1);
            end else if (gnt1) begin
                state <= OWN1;
                last  <= 1'b1;
                if (state != OWN1) beat_cnt <= CNT_W'(1);
                else if (!cnt_sat) beat_cnt <= beat_cnt + CNT_W'(1);
            end else begin
                state    <= IDLE;
                beat_cnt <= '0;
            end
        end
    end

    assign gnt0_o      = gnt0;
    assign gnt1_o      = gnt1;
    assign mem_we_o    = (gnt0 & we0_i) | (gnt1 & we1_i);
    assign mem_addr_o  = gnt1 ? addr1_i  : addr0_i;
    assign mem_wdata_o = gnt1 ? wdata1_i : wdata0_i;
    assign rdata0_o    = mem_rdata_i;
    assign rdata1_o    = mem_rdata_i;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM with registered read address,
// directed steps, read responses checked through an expected-response queue.
module tb_ram_port_arbiter;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       req0_i, we0_i, req1_i, we1_i;
    logic [5:0] addr0_i, addr1_i;
    logic [7:0] wdata0_i, wdata1_i;
    logic       gnt0_o, gnt1_o, rvalid0_o, rvalid1_o;
    logic [7:0] rdata0_o, rdata1_o;
    logic       mem_we_o;
    logic [5:0] mem_addr_o;
    logic [7:0] mem_wdata_o;
    logic [7:0] mem_rdata_i;

    always #5 clk_i = ~clk_i;

    ram_port_arbiter #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(6),
        .MAX_BURST (4)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req0_i     (req0_i),
        .we0_i      (we0_i),
        .addr0_i    (addr0_i),
        .wdata0_i   (wdata0_i),
        .req1_i     (req1_i),
        .we1_i      (we1_i),
        .addr1_i    (addr1_i),
        .wdata1_i   (wdata1_i),
        .gnt0_o     (gnt0_o),
        .gnt1_o     (gnt1_o),
        .rvalid0_o  (rvalid0_o),
        .rvalid1_o  (rvalid1_o),
        .rdata0_o   (rdata0_o),
        .rdata1_o   (rdata1_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i)
    );

    // Environment RAM: registered read address, write on mem_we_o.
    logic [7:0] ram [64];
    logic [5:0] ram_addr_q;
    always @(posedge clk_i) begin
        ram_addr_q <= mem_addr_o;
        if (mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
    end
    assign mem_rdata_i = ram[ram_addr_q];

    // Bench's own view of memory contents and pending responses.
    logic [7:0] model_mem [64];
    typedef struct {
        bit         port;
        logic [7:0] data;
    } resp_t;
    resp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive requests, check grants and the RAM command,
    // then after the edge check the read-response channel.
    task automatic step(input string tag, input bit rst,
                        input bit r0, input bit w0, input logic [5:0] a0, input logic [7:0] d0,
                        input bit r1, input bit w1, input logic [5:0] a1, input logic [7:0] d1,
                        input bit e0, input bit e1);
        resp_t r;
        bit    has;
        @(negedge clk_i);
        rst_ni = rst; req0_i = r0; we0_i = w0; addr0_i = a0; wdata0_i = d0;
        req1_i = r1; we1_i = w1; addr1_i = a1; wdata1_i = d1;
        #1;
        check({tag, ".gnt0"}, 32'(gnt0_o), 32'(e0));
        check({tag, ".gnt1"}, 32'(gnt1_o), 32'(e1));
        check({tag, ".mem_we"}, 32'(mem_we_o), 32'((e0 & w0) | (e1 & w1)));
        check({tag, ".mem_addr"}, 32'(mem_addr_o), 32'(e1 ? a1 : a0));
        if (e0 && w0) check({tag, ".mem_wdata"}, 32'(mem_wdata_o), 32'(d0));
        if (e1 && w1) check({tag, ".mem_wdata"}, 32'(mem_wdata_o), 32'(d1));
        if (e0 && !w0) sb.push_back('{port: 1'b0, data: model_mem[a0]});
        if (e1 && !w1) sb.push_back('{port: 1'b1, data: model_mem[a1]});
        if (e0 && w0) model_mem[a0] = d0;
        if (e1 && w1) model_mem[a1] = d1;
        @(posedge clk_i);
        #1;
        has = (sb.size() > 0);
        if (has) r = sb.pop_front();
        check({tag, ".rvalid0"}, 32'(rvalid0_o), 32'(has && !r.port));
        check({tag, ".rvalid1"}, 32'(rvalid1_o), 32'(has && r.port));
        if (has && !r.port) check({tag, ".rdata0"}, 32'(rdata0_o), 32'(r.data));
        if (has && r.port)  check({tag, ".rdata1"}, 32'(rdata1_o), 32'(r.data));
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            ram[i]       = 8'(i) ^ 8'hA0;
            model_mem[i] = 8'(i) ^ 8'hA0;
        end
        rst_ni = 1'b0; req0_i = 1'b0; we0_i = 1'b0; addr0_i = '0; wdata0_i = '0;
        req1_i = 1'b0; we1_i = 1'b0; addr1_i = '0; wdata1_i = '0;

        // Reset held with both ports requesting writes: nothing may be granted.
        for (int i = 0; i < 3; i++)
            step("reset", 1'b0, 1'b1, 1'b1, 6'd1, 8'h11, 1'b1, 1'b1, 6'd2, 8'h22, 1'b0, 1'b0);

        // Both ports read continuously from reset release.
        for (int i = 0; i < 10; i++) begin
            bit p;
`ifdef ARB_FIXED_PRI_EN
            p = 1'b0;
`else
            p = ((i / 4) % 2) == 1;
`endif
            step("burst", 1'b1, 1'b1, 1'b0, 6'(i), 8'h00, 1'b1, 1'b0, 6'(32 + i), 8'h00, !p, p);
        end

        step("idle", 1'b1, 1'b0, 1'b0, 6'd0, 8'h00, 1'b0, 1'b0, 6'd0, 8'h00, 1'b0, 1'b0);

        // Port 0 alone reads address 5 (holds 8'hA5).
        step("rd5", 1'b1, 1'b1, 1'b0, 6'd5, 8'h00, 1'b0, 1'b0, 6'd0, 8'h00, 1'b1, 1'b0);

        // Port 1 writes 8'h3C to the top address; port 0 reads it back next cycle.
        step("wr63", 1'b1, 1'b0, 1'b0, 6'd0, 8'h00, 1'b1, 1'b1, 6'd63, 8'h3C, 1'b0, 1'b1);
        step("rd63", 1'b1, 1'b1, 1'b0, 6'd63, 8'h00, 1'b0, 1'b0, 6'd0, 8'h00, 1'b1, 1'b0);

        // Port 1 mid-read when reset hits; afterwards a tie must go to port 0.
        step("own1", 1'b1, 1'b0, 1'b0, 6'd0, 8'h00, 1'b1, 1'b0, 6'd10, 8'h00, 1'b0, 1'b1);
        step("midrst", 1'b0, 1'b0, 1'b0, 6'd0, 8'h00, 1'b1, 1'b0, 6'd11, 8'h00, 1'b0, 1'b0);
        step("postrst", 1'b1, 1'b1, 1'b0, 6'd20, 8'h00, 1'b1, 1'b0, 6'd21, 8'h00, 1'b1, 1'b0);

        // Port 1 alone keeps the grant beyond MAX_BURST; port 0 then wins at once.
        for (int i = 0; i < 6; i++)
            step("p1solo", 1'b1, 1'b0, 1'b0, 6'd0, 8'h00, 1'b1, 1'b0, 6'(40 + i), 8'h00, 1'b0, 1'b1);
        step("p0cut", 1'b1, 1'b1, 1'b0, 6'd50, 8'h00, 1'b1, 1'b0, 6'd51, 8'h00, 1'b1, 1'b0);
        step("drain", 1'b1, 1'b0, 1'b0, 6'd0, 8'h00, 1'b0, 1'b0, 6'd0, 8'h00, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
